uart_tx_frame_serializer: RTL and testbench
===========================================

Name: uart_tx_frame_serializer

Overview:
UART transmitter: the transmit-side counterpart of the RX edge/bit counter path. Accepts a parallel byte with a valid strobe and serializes it onto TX_OUT as start bit, data LSB-first, optional parity bit and stop bit. One bit per CLK cycle, so CLK is the already-divided TX baud clock. Fed by the TX async FIFO read side, which pops on the BUSY falling edge.

Parameters:
DATA_WIDTH, 8, payload bits per frame (bit counter width = clog2(DATA_WIDTH))

Ports:
CLK  input  1  TX baud clock, one serial bit per rising edge
RST  input  1  asynchronous, active-low reset
P_DATA  input  DATA_WIDTH  parallel payload
DATA_VALID  input  1  payload valid; level-sensitive
PAR_EN  input  1  1 = append parity bit
PAR_TYP  input  1  0 = even, 1 = odd parity
TX_OUT  output  1  serial line, idle high
BUSY  output  1  high while a frame is on the line

Behaviour:
- Reset is asynchronous, active-low, on RST; clock is CLK. During reset: state=IDLE, TX_OUT=1, BUSY=0, internal data/parity registers=0.
- TX_OUT and BUSY are registered: no combinational path from inputs to outputs.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, BUSY=0. At a rising edge with DATA_VALID=1, the block:
  - latches P_DATA, PAR_EN and PAR_TYP;
  - computes parity: even = XOR of data bits; odd = inverted XOR;
  - goes to START.
  Latency: the start bit appears on TX_OUT in the cycle after the accepting edge.
- START: TX_OUT=0, BUSY=1, lasts 1 cycle, then goes to DATA with bit index=0.
- DATA: TX_OUT=data[index], LSB first, 1 cycle per bit. After index DATA_WIDTH-1, goes to PARITY if the latched PAR_EN=1, else to STOP. The index does not wrap within a frame.
- PARITY: TX_OUT=latched parity bit, 1 cycle, then goes to STOP.
- STOP: TX_OUT=1, BUSY=1, 1 cycle, then goes to IDLE. DATA_VALID is not sampled in STOP.
- Frame length with BUSY=1 is 1+DATA_WIDTH+1 = 10 cycles without parity, or 11 cycles with parity (DATA_WIDTH=8).
- Minimum inter-frame gap is one IDLE cycle (TX_OUT=1, BUSY=0). If DATA_VALID is held high, the next frame is accepted at the edge ending that IDLE cycle.
- DATA_VALID outside IDLE is ignored. It is not queued and not an error.
- P_DATA, PAR_EN and PAR_TYP changes mid-frame have no effect on the current frame.
- Reset asserted mid-frame immediately forces TX_OUT=1 and BUSY=0. A truncated frame is acceptable. After release, the block is in IDLE.
- No X propagation: the default branch of the FSM returns to IDLE with outputs idle.

Test Plan:
- Reset check: hold RST=0 with DATA_VALID=1 -> TX_OUT=1, BUSY=0 throughout. Release RST -> a frame starts one edge later.
- Even parity frame: P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, single-cycle DATA_VALID -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1. BUSY=1 for exactly 11 cycles, then TX_OUT=1 and BUSY=0.
- Odd parity frame: P_DATA=0x00, PAR_EN=1, PAR_TYP=1 -> 0,0,0,0,0,0,0,0,0,1,1. P_DATA=0x01 odd -> parity bit 0.
- No parity frame: P_DATA=0xFF, PAR_EN=0 -> 0,1,1,1,1,1,1,1,1,1. BUSY high for 10 cycles.
- Back-to-back frames: DATA_VALID held high. P_DATA=0x3C changes to 0xC3 during the DATA state of frame 1 -> frame 1 transmits 0x3C unchanged, exactly one idle cycle follows, frame 2 transmits 0xC3. Extra DATA_VALID during BUSY creates no additional frame.
- Reset mid-frame: assert RST during the 4th data bit -> TX_OUT=1 and BUSY=0 asynchronously. After release with DATA_VALID=0, the line stays idle with no residual bits.

Source files
------------

// File: rtl/uart_tx_frame_serializer_if.sv
// Parallel-in / serial-out bundle for the UART TX frame serializer.
// master drives payload and strobe, slave produces the serial line.
interface uart_tx_frame_serializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  BUSY;

    modport master (
        output P_DATA,
        output DATA_VALID,
        output PAR_EN,
        output PAR_TYP,
        input  TX_OUT,
        input  BUSY
    );

    modport slave (
        input  P_DATA,
        input  DATA_VALID,
        input  PAR_EN,
        input  PAR_TYP,
        output TX_OUT,
        output BUSY
    );
endinterface

// File: rtl/uart_tx_frame_serializer.sv
// UART TX serializer: start, LSB-first data, optional parity, stop.
// One bit per CLK edge; TX_OUT and BUSY come straight from flops.
module uart_tx_frame_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                        CLK,
    input  logic                        RST,
    uart_tx_frame_serializer_if.slave   bus
);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e                state_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_q;
    logic                  par_en_q;
    logic [IW-1:0]         idx_q;
    logic [IW-1:0]         idx_d;
    logic                  tx_q;
    logic                  busy_q;

    // Next bit index, only consumed while shifting data bits.
    always_comb begin
        idx_d = idx_q + IW'(1);
    end

    // Frame FSM; each transition also loads the line value for the next bit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            data_q   <= '0;
            par_q    <= 1'b0;
            par_en_q <= 1'b0;
            idx_q    <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (bus.DATA_VALID) begin
                        data_q   <= bus.P_DATA;
                        par_en_q <= bus.PAR_EN;
                        par_q    <= (^bus.P_DATA) ^ bus.PAR_TYP;
                        idx_q    <= '0;
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= START;
                    end
                end
                START: begin
                    idx_q   <= '0;
                    tx_q    <= data_q[0];
                    state_q <= DATA;
                end
                DATA: begin
                    if (idx_q == LAST_IDX) begin
                        if (par_en_q) begin
                            tx_q    <= par_q;
                            state_q <= PARITY;
                        end else begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end
                    end else begin
                        idx_q <= idx_d;
                        tx_q  <= data_q[idx_d];
                    end
                end
                PARITY: begin
                    tx_q    <= 1'b1;
                    state_q <= STOP;
                end
                STOP: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.TX_OUT = tx_q;
    assign bus.BUSY   = busy_q;
endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// Directed bench for uart_tx_frame_serializer: frame table plus
// hand-written reset, back-to-back and mid-frame reset sequences.
module tb_uart_tx_frame_serializer;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    uart_tx_frame_serializer_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_frame_serializer #(.DATA_WIDTH(8)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // seq is in line order: seq[10] is the start bit, seq[10-i] is bit i.
    typedef struct {
        logic [7:0]  data;
        logic        par_en;
        logic        par_typ;
        logic [10:0] seq;
        int          len;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, " tx"}, bus.TX_OUT, 1'b1);
        chk({name, " busy"}, bus.BUSY, 1'b0);
    endtask

    // Called right after the accepting edge; walks every busy cycle.
    task automatic frame(input string name, input logic [10:0] seq, input int len);
        for (int i = 0; i < len; i++) begin
            chk($sformatf("%s bit%0d", name, i), bus.TX_OUT, seq[10-i]);
            chk($sformatf("%s busy%0d", name, i), bus.BUSY, 1'b1);
            tick();
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 11'b01010010101, 11};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 11'b00000000011, 11};
        vecs[2] = '{8'h01, 1'b1, 1'b1, 11'b01000000001, 11};
        vecs[3] = '{8'hFF, 1'b0, 1'b0, 11'b01111111110, 10};
        vecs[4] = '{8'h0F, 1'b1, 1'b0, 11'b01111000001, 11};
        vecs[5] = '{8'h80, 1'b1, 1'b1, 11'b00000000101, 11};

        bus.P_DATA     = 8'h00;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        bus.DATA_VALID = 1'b1;
        rst_n          = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk_idle("reset t0");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle($sformatf("reset hold%0d", i));
        end

        rst_n = 1'b1;
        tick();
        bus.DATA_VALID = 1'b0;
        frame("post-reset", 11'b00000000010, 10);
        chk_idle("post-reset end");

        foreach (vecs[k]) begin
            bus.P_DATA     = vecs[k].data;
            bus.PAR_EN     = vecs[k].par_en;
            bus.PAR_TYP    = vecs[k].par_typ;
            bus.DATA_VALID = 1'b1;
            tick();
            bus.DATA_VALID = 1'b0;
            bus.P_DATA     = ~vecs[k].data;
            bus.PAR_EN     = ~vecs[k].par_en;
            bus.PAR_TYP    = ~vecs[k].par_typ;
            frame($sformatf("vec%0d", k), vecs[k].seq, vecs[k].len);
            chk_idle($sformatf("vec%0d end", k));
            tick();
            chk_idle($sformatf("vec%0d gap", k));
        end

        bus.P_DATA     = 8'h3C;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        bus.DATA_VALID = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("b2b f1 bit%0d", i), bus.TX_OUT, logic'(11'b00011110010 >> (10 - i)));
            chk($sformatf("b2b f1 busy%0d", i), bus.BUSY, 1'b1);
            if (i == 3) bus.P_DATA = 8'hC3;
            tick();
        end
        chk_idle("b2b gap");
        tick();
        bus.DATA_VALID = 1'b0;
        frame("b2b f2", 11'b01100001110, 10);
        for (int i = 0; i < 3; i++) begin
            chk_idle($sformatf("b2b tail%0d", i));
            tick();
        end

        bus.P_DATA     = 8'h55;
        bus.PAR_EN     = 1'b1;
        bus.PAR_TYP    = 1'b0;
        bus.DATA_VALID = 1'b1;
        tick();
        bus.DATA_VALID = 1'b0;
        for (int i = 0; i <= 4; i++) begin
            chk($sformatf("midrst bit%0d", i), bus.TX_OUT, logic'(i[0]));
            chk($sformatf("midrst busy%0d", i), bus.BUSY, 1'b1);
            if (i < 4) tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("midrst async");
        tick();
        chk_idle("midrst hold");
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk_idle($sformatf("midrst after%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
